muldiv_unit: RTL and testbench

- Iterative multiply/divide responder for the pipelined core.
- The execute stage issues a MULT, MULTU, DIV or DIVU request with a one-cycle start pulse.
- The unit computes over 32 cycles and writes the HI/LO result registers.
- While the unit is busy, the core stalls on HI/LO reads; mthi/mtlo write the HI/LO registers directly.

---
 rtl/muldiv_unit_if.sv | 31 +++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the execute stage and the
// iterative multiply/divide unit.
//   master (core side): drives start, op, a, b, cancel, mthi, mtlo, wd;
//                       observes busy, done, hi, lo.
//   slave  (unit side): the mirror image of master.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, mthi, mtlo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, mthi, mtlo, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - muldiv_unit_if.slave:
//          start/op/a/b  request (op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//          cancel        pipeline flush, aborts an operation in flight
//          mthi/mtlo/wd  direct HI/LO writes, honoured only when not busy
//          busy/done     operation in flight / one-cycle commit pulse
//          hi/lo         result registers
// A request accepted at edge N runs one step per edge for WIDTH edges and
// commits on the last step, so done and the new hi/lo appear WIDTH+1
// cycles after the request.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        count;
  logic                 is_div;
  logic                 b_zero;
  logic                 neg_res;
  logic                 neg_rem;
  logic [WIDTH-1:0]     a_raw;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   work;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 accept;
  logic                 step;
  logic                 commit;

  logic                 signed_in;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  logic [WIDTH:0]       mul_acc;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   work_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control. DONE accepts a new request exactly
  // like IDLE so results can be issued back to back; cancel always beats
  // start in the same cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start && !bus.cancel) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            commit     = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand preparation: signed ops iterate on magnitudes and fix signs
  // at commit time.
  always_comb begin
    signed_in = ~bus.op[0];
    a_neg     = signed_in & bus.a[WIDTH-1];
    b_neg     = signed_in & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
  end

  // One iteration. work holds {accumulator, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide; both shift one bit per step.
  always_comb begin
    mul_acc   = {1'b0, work[2*WIDTH-1:WIDTH]} +
                (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_acc, work[WIDTH-1:1]};
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ok    = (div_shift >= {1'b0, opnd});
    div_next  = div_ok ? {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    work_next = is_div ? div_next : mul_next;
  end

  // Sign correction on the final step. The remainder follows the dividend;
  // divide by zero bypasses the iteration result entirely.
  always_comb begin
    prod_fix = neg_res ? -work_next : work_next;
    quo      = work_next[WIDTH-1:0];
    rem      = work_next[2*WIDTH-1:WIDTH];
    if (is_div) begin
      if (b_zero) begin
        res_lo = {WIDTH{1'b1}};
        res_hi = a_raw;
      end else begin
        res_lo = neg_res ? -quo : quo;
        res_hi = neg_rem ? -rem : rem;
      end
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath and HI/LO. A commit can only happen while busy, so it never
  // competes with mthi/mtlo; a direct write alongside an accepted start
  // lands now and is overwritten when that operation commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      a_raw   <= '0;
      opnd    <= '0;
      work    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (accept) begin
        count   <= '0;
        is_div  <= bus.op[1];
        b_zero  <= (bus.b == '0);
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        a_raw   <= bus.a;
        opnd    <= bus.op[1] ? b_mag : a_mag;
        work    <= bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      end else if (step) begin
        count <= count + 1'b1;
        work  <= work_next;
      end

      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state != RUN) begin
        if (bus.mthi) begin
          hi_q <= bus.wd;
        end
        if (bus.mtlo) begin
          lo_q <= bus.wd;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Results are compared
// against a plain 64-bit arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {hi, lo} from the architectural definition.
  function automatic logic [63:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: begin
        if (b == 32'h0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else            p = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Observe from just after the accepting edge until done, bounded.
  task automatic wait_result(output int busy_cnt, output bit done_seen);
    busy_cnt  = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        done_seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.hi !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_hi: got %h want %h", bus.hi, 32'h0);
    end
    n_checks++;
    if (bus.lo !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_lo: got %h want %h", bus.lo, 32'h0);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_done: got %b want 0", bus.done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] as  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] bs  [3] = '{32'h5, 32'hFFFF_FFFF, 32'h2};
    logic [63:0] want[3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001,
                             64'hFFFF_FFFF_FFFF_FFFD};
    int busy_cnt;
    bit done_seen;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_result(busy_cnt, done_seen);
      n_checks++;
      if (busy_cnt !== 32) begin
        n_fail++; $display("[TB] FAIL dir%0d_busy_cycles: got %0d want 32", i, busy_cnt);
      end
      n_checks++;
      if (done_seen !== 1'b1) begin
        n_fail++; $display("[TB] FAIL dir%0d_done: got %b want 1", i, done_seen);
      end
      n_checks++;
      if ({bus.hi, bus.lo} !== want[i]) begin
        n_fail++; $display("[TB] FAIL dir%0d_result: got %h want %h", i, {bus.hi, bus.lo}, want[i]);
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++; $display("[TB] FAIL dir%0d_done_pulse: got %b want 0", i, bus.done);
      end
    end
  endtask

  task automatic test_div_boundary();
    int busy_cnt;
    bit done_seen;
    issue(2'b11, 32'd100, 32'd0);
    wait_result(busy_cnt, done_seen);
    n_checks++;
    if (done_seen !== 1'b1 || busy_cnt !== 32) begin
      n_fail++; $display("[TB] FAIL divzero_timing: got done %b busy %0d want 1/32", done_seen, busy_cnt);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0064_FFFF_FFFF) begin
      n_fail++; $display("[TB] FAIL divzero_result: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
    end
    tick();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(busy_cnt, done_seen);
    n_checks++;
    if (done_seen !== 1'b1) begin
      n_fail++; $display("[TB] FAIL overflow_done: got %b want 1", done_seen);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000) begin
      n_fail++; $display("[TB] FAIL overflow_result: got %h want %h", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    end
    tick();
  endtask

  task automatic test_cancel();
    int busy_cnt;
    bit done_seen;
    int done_cnt;
    issue(2'b01, 32'h10, 32'h20);
    wait_result(busy_cnt, done_seen);
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h200) begin
      n_fail++; $display("[TB] FAIL cancel_prior: got %h want %h", {bus.hi, bus.lo}, 64'h200);
    end
    tick();
    issue(2'b11, 32'd1000, 32'd7);
    repeat (9) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cancel_busy: got %b want 0", bus.busy);
    end
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    n_checks++;
    if (done_cnt !== 0) begin
      n_fail++; $display("[TB] FAIL cancel_no_done: got %0d pulses want 0", done_cnt);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h200) begin
      n_fail++; $display("[TB] FAIL cancel_hold: got %h want %h", {bus.hi, bus.lo}, 64'h200);
    end
    bus.cancel = 1'b1;
    issue(2'b01, 32'd3, 32'd3);
    bus.cancel = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL cancel_start_same_cycle: got busy %b want 0", bus.busy);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    int busy_cnt;
    bit done_seen;
    issue(2'b01, 32'd6, 32'd7);
    repeat (5) tick();
    bus.op    = 2'b11;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    bus.mthi  = 1'b1;
    bus.wd    = 32'h1234;
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    wait_result(busy_cnt, done_seen);
    n_checks++;
    if (done_seen !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ignore_done: got %b want 1", done_seen);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'd42) begin
      n_fail++; $display("[TB] FAIL ignore_result: got %h want %h", {bus.hi, bus.lo}, 64'd42);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ignore_no_restart: got busy %b want 0", bus.busy);
    end
    bus.mtlo = 1'b1;
    bus.wd   = 32'hABCD;
    tick();
    bus.mtlo = 1'b0;
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_ABCD) begin
      n_fail++; $display("[TB] FAIL mtlo_idle: got %h want %h", {bus.hi, bus.lo}, 64'hABCD);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    bit done_seen;
    issue(2'b01, 32'd5, 32'd5);
    wait_result(busy_cnt, done_seen);
    issue(2'b01, 32'd2, 32'd3);
    wait_result(busy_cnt, done_seen);
    n_checks++;
    if (busy_cnt !== 32 || done_seen !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_timing: got busy %0d done %b want 32/1", busy_cnt, done_seen);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'd6) begin
      n_fail++; $display("[TB] FAIL b2b_result: got %h want %h", {bus.hi, bus.lo}, 64'd6);
    end
    bus.mthi = 1'b1;
    bus.wd   = 32'h55;
    tick();
    bus.mthi = 1'b0;
    n_checks++;
    if ({bus.hi, bus.lo} !== {32'h55, 32'd6}) begin
      n_fail++; $display("[TB] FAIL mthi_done_cycle: got %h want %h", {bus.hi, bus.lo}, {32'h55, 32'd6});
    end
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.wd   = 32'h77;
    issue(2'b01, 32'd3, 32'd4);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    n_checks++;
    if ({bus.hi, bus.lo, bus.busy} !== {32'h77, 32'h77, 1'b1}) begin
      n_fail++; $display("[TB] FAIL mt_with_start: got %h/%h busy %b want 77/77 busy 1", bus.hi, bus.lo, bus.busy);
    end
    wait_result(busy_cnt, done_seen);
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'd12 || done_seen !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mt_then_result: got %h done %b want %h", {bus.hi, bus.lo}, done_seen, 64'd12);
    end
  endtask

  task automatic test_random();
    int          busy_cnt;
    bit          done_seen;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] want;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      want = ref_model(op, a, b);
      issue(op, a, b);
      wait_result(busy_cnt, done_seen);
      n_checks++;
      if (done_seen !== 1'b1 || busy_cnt !== 32) begin
        n_fail++; $display("[TB] FAIL rand%0d_timing: got done %b busy %0d want 1/32", i, done_seen, busy_cnt);
      end
      n_checks++;
      if ({bus.hi, bus.lo} !== want) begin
        n_fail++; $display("[TB] FAIL rand%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, b, {bus.hi, bus.lo}, want);
      end
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      n_fail++; $display("[TB] FAIL midrun_reset_hilo: got %h want 0", {bus.hi, bus.lo});
    end
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL midrun_reset_flags: got busy/done %b want 00", {bus.busy, bus.done});
    end
    repeat (3) tick();
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL midrun_reset_stays_idle: got busy/done %b want 00", {bus.busy, bus.done});
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.a      = '0;
    bus.b      = '0;
    bus.cancel = 1'b0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.wd     = '0;
    test_reset();
    test_directed();
    test_div_boundary();
    test_cancel();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
